// File: rtl/lsu_stage.sv
// Load/store pipeline stage. Each memory op issues one pipelined Wishbone access, and the
// stage reports misalignment, bus errors and timeouts. Non-memory ops pass through in one cycle.
module lsu_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ce,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic              i_is_load,
    input  logic              i_is_store,
    input  logic [2:0]        i_func3,
    input  logic              i_wr_rd,
    input  logic [4:0]        i_rd_addr,
    input  logic [XLEN-1:0]   i_rd_val,
    output logic              o_ce,
    output logic              o_wr_rd,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_rd_val,
    output logic [4:0]        o_rd_addr,
    output logic              o_stall,
    output logic              o_flush,
    output logic              o_exc,
    output logic [3:0]        o_exc_cause,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [XLEN/8-1:0] o_wb_sel,
    output logic [XLEN-1:0]   o_wb_addr,
    output logic [XLEN-1:0]   o_wb_wdata,
    input  logic [XLEN-1:0]   i_wb_rdata,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic              i_wb_err
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t          state_r;
    logic [15:0]     tmo_cnt_r;
    logic            flushed_r;
    logic            pend_exc_r;
    logic            pend_wr_rd_r;
    logic [2:0]      func3_r;
    logic            is_store_r;
    logic            wr_rd_r;
    logic [OFFW-1:0] off_r;

    logic            accept_s;
    logic            mem_op_s;
    logic            bad_s;
    logic            timeout_s;
    logic            bus_done_s;
    logic            res_exc_s;
    logic            res_wr_s;
    logic [3:0]      res_cause_s;
    logic [XLEN-1:0] res_val_s;

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFFW-1:0] off);
        logic [NB-1:0] m;
        case (sz)
            2'b00:   m = NB'(8'h01);
            2'b01:   m = NB'(8'h03);
            2'b10:   m = NB'(8'h0F);
            default: m = NB'(8'hFF);
        endcase
        return m << off;
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [1:0] sz, input logic [XLEN-1:0] d);
        case (sz)
            2'b00:   return {NB{d[7:0]}};
            2'b01:   return {(XLEN/16){d[15:0]}};
            2'b10:   return {(XLEN/32){d[31:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the addressed lanes down to bit 0, then sign- or zero-extend by access width.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] raw,
                                                 input logic [OFFW-1:0] off);
        logic [XLEN-1:0] d;
        d = raw >> {off, 3'b000};
        case (f3)
            3'b000:  return XLEN'($signed(d[7:0]));
            3'b001:  return XLEN'($signed(d[15:0]));
            3'b010:  return XLEN'($signed(d[31:0]));
            3'b100:  return XLEN'(d[7:0]);
            3'b101:  return XLEN'(d[15:0]);
            3'b110:  return XLEN'(d[31:0]);
            default: return d;
        endcase
    endfunction

    assign accept_s   = (state_r == IDLE) && i_ce && !i_stall && !i_flush;
    assign mem_op_s   = i_is_load || i_is_store;
    assign timeout_s  = (tmo_cnt_r == TMO_LAST);
    assign bus_done_s = i_wb_ack || i_wb_err || timeout_s;
    assign o_stall    = (state_r != IDLE) || (o_ce && i_stall);
    assign o_flush    = i_flush;

    // Alignment and width legality of the incoming access.
    always_comb begin
        bad_s = 1'b0;
        case (i_func3[1:0])
            2'b00:   bad_s = 1'b0;
            2'b01:   bad_s = i_addr[0];
            2'b10:   bad_s = |i_addr[1:0];
            default: bad_s = (XLEN == 32) ? 1'b1 : |i_addr[2:0];
        endcase
    end

    // Completion result. An error beats an ack, and an ack beats a timeout.
    always_comb begin
        res_exc_s   = i_wb_err || (timeout_s && !i_wb_ack);
        res_cause_s = res_exc_s ? (is_store_r ? 4'd7 : 4'd5) : 4'd0;
        res_wr_s    = !res_exc_s && !is_store_r && wr_rd_r;
        res_val_s   = load_ext(func3_r, i_wb_rdata, off_r);
    end

    // Stage control FSM. All result and bus outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            tmo_cnt_r    <= 16'd0;
            flushed_r    <= 1'b0;
            pend_exc_r   <= 1'b0;
            pend_wr_rd_r <= 1'b0;
            func3_r      <= 3'd0;
            is_store_r   <= 1'b0;
            wr_rd_r      <= 1'b0;
            off_r        <= '0;
            o_ce         <= 1'b0;
            o_wr_rd      <= 1'b0;
            o_pc         <= '0;
            o_rd_val     <= '0;
            o_rd_addr    <= 5'd0;
            o_exc        <= 1'b0;
            o_exc_cause  <= 4'd0;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_sel     <= '0;
            o_wb_addr    <= '0;
            o_wb_wdata   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        o_pc      <= i_pc;
                        o_rd_addr <= i_rd_addr;
                        tmo_cnt_r <= 16'd0;
                        flushed_r <= 1'b0;
                        if (!mem_op_s) begin
                            o_ce        <= 1'b1;
                            o_wr_rd     <= i_wr_rd;
                            o_rd_val    <= i_rd_val;
                            o_exc       <= 1'b0;
                            o_exc_cause <= 4'd0;
                        end else if (bad_s) begin
                            o_ce        <= 1'b1;
                            o_wr_rd     <= 1'b0;
                            o_rd_val    <= i_addr;
                            o_exc       <= 1'b1;
                            o_exc_cause <= i_is_store ? 4'd6 : 4'd4;
                        end else begin
                            o_ce        <= 1'b0;
                            o_wr_rd     <= 1'b0;
                            o_exc       <= 1'b0;
                            o_exc_cause <= 4'd0;
                            state_r     <= REQ;
                            o_wb_cyc    <= 1'b1;
                            o_wb_stb    <= 1'b1;
                            o_wb_we     <= i_is_store;
                            o_wb_addr   <= {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                            o_wb_sel    <= lane_mask(i_func3[1:0], i_addr[OFFW-1:0]);
                            o_wb_wdata  <= store_data(i_func3[1:0], i_rs2);
                            func3_r     <= i_func3;
                            is_store_r  <= i_is_store;
                            wr_rd_r     <= i_wr_rd;
                            off_r       <= i_addr[OFFW-1:0];
                        end
                    end else if (i_flush || !i_stall) begin
                        o_ce <= 1'b0;
                    end else begin
                        o_ce <= o_ce;
                    end
                end
                REQ, WAIT: begin
                    tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    if (i_flush) begin
                        flushed_r <= 1'b1;
                    end
                    if (bus_done_s) begin
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                        o_rd_val     <= res_val_s;
                        o_exc_cause  <= res_cause_s;
                        pend_exc_r   <= res_exc_s;
                        pend_wr_rd_r <= res_wr_s;
                        if (flushed_r || i_flush) begin
                            o_ce        <= 1'b0;
                            o_exc       <= 1'b0;
                            o_wr_rd     <= 1'b0;
                            o_exc_cause <= 4'd0;
                            state_r     <= IDLE;
                        end else if (!i_stall) begin
                            o_ce    <= 1'b1;
                            o_exc   <= res_exc_s;
                            o_wr_rd <= res_wr_s;
                            state_r <= IDLE;
                        end else begin
                            state_r <= DONE;
                        end
                    end else if ((state_r == REQ) && !i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        state_r  <= WAIT;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DONE: begin
                    if (i_flush) begin
                        o_exc_cause <= 4'd0;
                        state_r     <= IDLE;
                    end else if (!i_stall) begin
                        o_ce    <= 1'b1;
                        o_exc   <= pend_exc_r;
                        o_wr_rd <= pend_wr_rd_r;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage (XLEN=32, TIMEOUT=4). A vector table is followed by
// hand-written sequences for timeout, stall, flush and reset.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_ce = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
    logic [31:0] i_pc = '0, i_addr = '0, i_rs2 = '0, i_rd_val = '0;
    logic        i_is_load = 1'b0, i_is_store = 1'b0, i_wr_rd = 1'b0;
    logic [2:0]  i_func3 = 3'd0;
    logic [4:0]  i_rd_addr = 5'd0;
    logic        o_ce, o_wr_rd, o_stall, o_flush, o_exc, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_pc, o_rd_val, o_wb_addr, o_wb_wdata;
    logic [4:0]  o_rd_addr;
    logic [3:0]  o_exc_cause, o_wb_sel;
    logic [31:0] i_wb_rdata = '0;
    logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0, i_wb_err = 1'b0;

    int tests = 0;
    int fails = 0;

    lsu_stage #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
        .i_pc(i_pc), .i_addr(i_addr), .i_rs2(i_rs2), .i_is_load(i_is_load),
        .i_is_store(i_is_store), .i_func3(i_func3), .i_wr_rd(i_wr_rd),
        .i_rd_addr(i_rd_addr), .i_rd_val(i_rd_val), .o_ce(o_ce), .o_wr_rd(o_wr_rd),
        .o_pc(o_pc), .o_rd_val(o_rd_val), .o_rd_addr(o_rd_addr), .o_stall(o_stall),
        .o_flush(o_flush), .o_exc(o_exc), .o_exc_cause(o_exc_cause), .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel), .o_wb_addr(o_wb_addr),
        .o_wb_wdata(o_wb_wdata), .i_wb_rdata(i_wb_rdata), .i_wb_ack(i_wb_ack),
        .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata;
        logic        err;
        logic        exp_bus;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata, exp_val;
        logic        exp_wr, exp_exc;
        logic [3:0]  exp_cause;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc);
        @(negedge clk);
        i_ce = 1'b1; i_is_load = ld; i_is_store = st; i_func3 = f3; i_addr = addr;
        i_rs2 = rs2; i_rd_val = rs2; i_pc = pc; i_wr_rd = 1'b1; i_rd_addr = 5'd7;
        @(negedge clk);
        i_ce = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] pc;
        pc = 32'h100 + 32'(idx * 4);
        issue(v.ld, v.st, v.f3, v.addr, v.rs2, pc);
        check($sformatf("v%0d_cyc", idx), o_wb_cyc, v.exp_bus);
        if (o_wb_cyc) begin
            check($sformatf("v%0d_stb", idx), o_wb_stb, 64'd1);
            check($sformatf("v%0d_we", idx), o_wb_we, v.st);
            check($sformatf("v%0d_sel", idx), o_wb_sel, v.exp_sel);
            check($sformatf("v%0d_addr", idx), o_wb_addr, v.addr & 32'hFFFF_FFFC);
            if (v.st) check($sformatf("v%0d_wdata", idx), o_wb_wdata, v.exp_wdata);
            i_wb_ack = 1'b1; i_wb_err = v.err; i_wb_rdata = v.rdata;
            @(negedge clk);
            i_wb_ack = 1'b0; i_wb_err = 1'b0;
            check($sformatf("v%0d_cyc_drop", idx), o_wb_cyc, 64'd0);
        end
        check($sformatf("v%0d_ce", idx), o_ce, 64'd1);
        check($sformatf("v%0d_wr", idx), o_wr_rd, v.exp_wr);
        check($sformatf("v%0d_exc", idx), o_exc, v.exp_exc);
        check($sformatf("v%0d_cause", idx), o_exc_cause, v.exp_cause);
        check($sformatf("v%0d_pc", idx), o_pc, pc);
        check($sformatf("v%0d_rd", idx), o_rd_addr, 64'd7);
        if (!v.st && !v.exp_exc) check($sformatf("v%0d_val", idx), o_rd_val, v.exp_val);
    endtask

    initial begin
        int n;
        // ld st f3 addr rs2 rdata err | bus sel wdata val wr exc cause
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h2002, 32'h0, 32'h0080_0000, 1'b0, 1'b1, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 32'h0080_0000, 1'b0, 1'b1, 4'b0100, 32'h0, 32'h0000_0080, 1'b1, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 32'h8001_1234, 1'b0, 1'b1, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h8001_1234, 1'b0, 1'b1, 4'b1100, 32'h0, 32'h0000_8001, 1'b1, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000_7F00, 1'b0, 1'b1, 4'b0010, 32'h0, 32'h0000_007F, 1'b1, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h4002, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 4'b1100, 32'h5678_5678, 32'h0, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h4004, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 4'd4};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h4001, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 4'd6};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h4000, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 4'd4};
        vecs[12] = '{1'b0, 1'b0, 3'b000, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 4'd0};
        vecs[13] = '{1'b0, 1'b1, 3'b010, 32'h5000, 32'h1122_3344, 32'h0, 1'b1, 1'b1, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 1'b1, 4'd7};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h5555_5555, 1'b1, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 4'd5};
        vecs[15] = '{1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'hAB00_0000, 1'b0, 1'b1, 4'b1000, 32'h0, 32'h0000_00AB, 1'b1, 1'b0, 4'd0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ce", o_ce, 64'd0);
        check("rst_cyc", o_wb_cyc, 64'd0);
        check("rst_stall", o_stall, 64'd0);
        check("rst_val", o_rd_val, 64'd0);
        check("rst_cause", o_exc_cause, 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Flush in IDLE: no accept, and the pending o_ce is cleared
        @(negedge clk);
        i_ce = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_func3 = 3'b010; i_addr = 32'h3000; i_flush = 1'b1;
        #1 check("oflush", o_flush, 64'd1);
        @(negedge clk);
        i_ce = 1'b0; i_flush = 1'b0;
        check("iflush_ce", o_ce, 64'd0);
        check("iflush_cyc", o_wb_cyc, 64'd0);

        // Timeout with no ack: four bus cycles, then a load bus error
        issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h200);
        n = 0;
        while (o_wb_cyc && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("tmo_cycles", 64'(n), 64'd4);
        check("tmo_ce", o_ce, 64'd1);
        check("tmo_exc", o_exc, 64'd1);
        check("tmo_cause", o_exc_cause, 64'd5);
        check("tmo_wr", o_wr_rd, 64'd0);

        // Ack on the fourth bus cycle wins over the timeout
        issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h204);
        repeat (3) @(negedge clk);
        check("ack4_cyc", o_wb_cyc, 64'd1);
        i_wb_ack = 1'b1; i_wb_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        i_wb_ack = 1'b0;
        check("ack4_ce", o_ce, 64'd1);
        check("ack4_exc", o_exc, 64'd0);
        check("ack4_val", o_rd_val, 64'h0BAD_F00D);

        // Ack while stalled: hold in DONE, present on the first unstalled cycle, then hold under stall
        issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h208);
        i_stall = 1'b1; i_wb_ack = 1'b1; i_wb_rdata = 32'h1357_9BDF;
        @(negedge clk);
        i_wb_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stl_ce", o_ce, 64'd0);
            check("stl_stall", o_stall, 64'd1);
            check("stl_cyc", o_wb_cyc, 64'd0);
            if (k < 2) @(negedge clk);
        end
        i_stall = 1'b0;
        @(negedge clk);
        check("stl_out_ce", o_ce, 64'd1);
        check("stl_out_val", o_rd_val, 64'h1357_9BDF);
        i_stall = 1'b1;
        @(negedge clk);
        check("hold_ce", o_ce, 64'd1);
        check("hold_val", o_rd_val, 64'h1357_9BDF);
        check("hold_stall", o_stall, 64'd1);
        i_stall = 1'b0;
        @(negedge clk);
        check("hold_release", o_ce, 64'd0);

        // Flush during WAIT: bus runs to ack, result squashed, next op accepted normally
        issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h20C);
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        check("fl_cyc_hold", o_wb_cyc, 64'd1);
        @(negedge clk);
        i_wb_ack = 1'b1; i_wb_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        i_wb_ack = 1'b0;
        check("fl_ce", o_ce, 64'd0);
        check("fl_exc", o_exc, 64'd0);
        check("fl_cyc", o_wb_cyc, 64'd0);
        check("fl_idle", o_stall, 64'd0);
        run_vec(vecs[12], 12);
        run_vec(vecs[5], 5);

        // Reset mid-transaction drops the bus cycle at once
        issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h210);
        check("mid_cyc_pre", o_wb_cyc, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_cyc", o_wb_cyc, 64'd0);
        check("mid_rst_stb", o_wb_stb, 64'd0);
        check("mid_rst_stall", o_stall, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32, 64.
REQ-002 Parameter TIMEOUT, default 255, max bus cycles (REQ+WAIT) before timeout; range 1..65535.
REQ-003 Ports, one per line:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- i_ce / i_stall / i_flush  in  1 each  upstream valid / downstream stall / pipeline flush.
- i_pc, i_addr, i_rs2  in  XLEN each  PC / effective address from ALU / store data.
- i_is_load, i_is_store  in  1 each  op class; both 0 = non-memory op.
- i_func3  in  3  RV width/sign code.
- i_wr_rd  in  1  writeback enable.
- i_rd_addr  in  5  destination register.
- i_rd_val  in  XLEN  ALU result.
- o_ce, o_wr_rd  out  1 each  result valid / writeback enable.
- o_pc, o_rd_val  out  XLEN each  PC / result.
- o_rd_addr  out  5  destination register.
- o_stall, o_flush  out  1 each  stall / flush to upstream.
- o_exc  out  1  exception flag.
- o_exc_cause  out  4  exception code.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  bus cycle / strobe / write.
- o_wb_sel  out  XLEN/8  byte-lane mask.
- o_wb_addr, o_wb_wdata  out  XLEN each  bus address / write data.
- i_wb_rdata  in  XLEN  read data.
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  bus ack / stall / error.

Function
REQ-004 States IDLE, REQ, WAIT, DONE; o_stall SHALL equal (state != IDLE) or (state==IDLE and o_ce and i_stall), combinationally.
REQ-005 Accept: state IDLE, i_ce=1, i_stall=0, i_flush=0, at posedge; otherwise nothing captured.
REQ-006 Non-memory op accepted: next cycle o_ce=1, o_pc/o_wr_rd/o_rd_addr/o_rd_val = inputs, o_exc=0; latency 1.
REQ-007 Memory op accepted, aligned: next cycle state=REQ, o_wb_cyc=o_wb_stb=1, o_wb_we=i_is_store, o_wb_addr=i_addr with low log2(XLEN/8) bits cleared, o_ce=0.
REQ-008 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; doubleword (func3 x11, XLEN=64 only) requires addr[2:0]=0.
REQ-009 Misaligned or illegal width (func3 x11 at XLEN=32): no bus cycle; next cycle o_ce=1, o_wr_rd=0, o_exc=1, cause 4 (load) or 6 (store).
REQ-010 Store: o_wb_wdata = store data replicated across all lanes at access width; o_wb_sel = width mask (1/3/F/FF) shifted left by byte offset.
REQ-011 Load: o_wb_sel as for store; selected lanes shifted down; func3 000/001/010 sign-extend, 100/101/110 zero-extend, 011 full 64-bit.
REQ-012 REQ: o_wb_stb held with stable addr/sel/data until i_wb_stall=0; then stb drops, state WAIT (or completes if ack/err same cycle).
REQ-013 Completion (ack or err in REQ/WAIT): o_wb_cyc and o_wb_stb 0 next cycle; if i_stall=0 result to outputs, o_ce=1, state IDLE; else result buffered, state DONE.
REQ-014 DONE: hold buffered result; first cycle i_stall=0 presents it (o_ce=1) and returns IDLE.
REQ-015 Load result: o_rd_val = extended data, o_wr_rd = i_wr_rd. Store result: o_wr_rd=0.
REQ-016 i_wb_err: o_wr_rd=0, o_exc=1, cause 5 (load) or 7 (store); err and ack same cycle -> err wins.
REQ-017 Timeout counter clears on accept, increments each REQ/WAIT cycle; at TIMEOUT with no ack/err: cyc/stb drop, error result as REQ-016; ack on the TIMEOUT cycle -> ack wins.
REQ-018 i_flush in IDLE: o_ce<=0 next cycle, no accept. i_flush in REQ/WAIT/DONE: bus cycle runs to completion/timeout, result squashed (o_ce=0, o_exc=0), state IDLE.
REQ-019 o_flush = i_flush combinationally.
REQ-020 While o_ce=1 and i_stall=1, all result outputs hold.
REQ-021 o_wb_cyc never deasserts mid-transaction except on completion, timeout, or reset.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE, counter 0, and every registered output (o_ce, o_wr_rd, o_exc, o_exc_cause, o_pc, o_rd_addr, o_rd_val, o_wb_*) to 0; reset mid-transaction drops o_wb_cyc immediately.

Verification
REQ-023 SB, addr 0x1003, rs2 0xAB, XLEN=32 -> o_wb_sel=1000, o_wb_wdata=0xABABABAB, o_wb_we=1, o_wr_rd=0.
REQ-024 LB, addr 0x2002, rdata 0x0080_0000 -> o_rd_val=0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 LW addr 0x3002 -> no o_wb_cyc, o_exc=1, cause 4, one cycle after accept.
REQ-026 TIMEOUT=4, no ack -> cyc drops after 4 bus cycles, o_exc=1, cause 5; ack on cycle 4 -> normal result.
REQ-027 Ack while i_stall=1 for 3 cycles -> state DONE, o_ce=0, result on first cycle i_stall=0.
REQ-028 i_flush during WAIT, ack 2 cycles later -> o_ce stays 0, state IDLE, next op accepted normally.
